// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the handshaked multicycle MIPS controller:
//   - opcode / funct encodings of the supported instructions
//   - FSM state encodings (FETCH=0 .. MEMWB=9, TRAP=A)
//   - ALUOp_*, NPC_*, EXT_*, GPRSel_*, WDSel_* datapath control constants
//   - is_imm_alu(): true for the I-type ALU instructions (ori/addi/lui)
// ALUOp_* constants are 3 bits wide; the top zero-extends them to ALUOP_W.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Controller states, exported on state_o for debug
  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DCD    = 4'h1,
    S_EXE    = 4'h2,
    S_WB     = 4'h3,
    S_MA     = 4'h4,
    S_MR     = 4'h5,
    S_MW     = 4'h6,
    S_BRANCH = 4'h7,
    S_JMP    = 4'h8,
    S_MEMWB  = 4'h9,
    S_TRAP   = 4'hA
  } state_e;

  // ALU operations
  localparam logic [2:0] ALUOp_ADDU = 3'd0;
  localparam logic [2:0] ALUOp_SUBU = 3'd1;
  localparam logic [2:0] ALUOp_AND  = 3'd2;
  localparam logic [2:0] ALUOp_OR   = 3'd3;
  localparam logic [2:0] ALUOp_SLT  = 3'd4;
  localparam logic [2:0] ALUOp_LUI  = 3'd5;

  // Next-PC source
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGNED = 2'd1;
  localparam logic [1:0] EXT_UPPER  = 2'd2;

  // Register-file write address select
  localparam logic [1:0] GPRSel_RD  = 2'd0;
  localparam logic [1:0] GPRSel_RT  = 2'd1;
  localparam logic [1:0] GPRSel_RA  = 2'd2;

  // Register-file write data select
  localparam logic [1:0] WDSel_ALU  = 2'd0;
  localparam logic [1:0] WDSel_MEM  = 2'd1;
  localparam logic [1:0] WDSel_PC   = 2'd2;

  // I-type instructions that go through EXE/WB with an immediate B operand
  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ORI) || (op == OP_ADDI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ---------------------------------------------------------------------------
// mc_alu_dec
// Combinational instruction decoder: maps op/funct to the ALU operation used
// in EXE and flags whether the instruction is one the controller supports.
// Ports:
//   op     in  6  IR[31:26]
//   funct  in  6  IR[5:0]
//   alu_op out 3  ALUOp_* (ADDU for instructions that do not use the ALU)
//   legal  out 1  1 = supported instruction
// ---------------------------------------------------------------------------
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  // Opcode / funct lookup
  always_comb begin
    alu_op = ALUOp_ADDU;
    legal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin alu_op = ALUOp_ADDU; legal = 1'b1; end
          FN_SUBU: begin alu_op = ALUOp_SUBU; legal = 1'b1; end
          FN_AND:  begin alu_op = ALUOp_AND;  legal = 1'b1; end
          FN_OR:   begin alu_op = ALUOp_OR;   legal = 1'b1; end
          FN_SLT:  begin alu_op = ALUOp_SLT;  legal = 1'b1; end
          FN_JR:   begin alu_op = ALUOp_ADDU; legal = 1'b1; end
          default: begin alu_op = ALUOp_ADDU; legal = 1'b0; end
        endcase
      end
      OP_ORI:  begin alu_op = ALUOp_OR;   legal = 1'b1; end
      OP_ADDI: begin alu_op = ALUOp_ADDU; legal = 1'b1; end
      OP_LUI:  begin alu_op = ALUOp_LUI;  legal = 1'b1; end
      OP_BEQ,
      OP_BNE:  begin alu_op = ALUOp_SUBU; legal = 1'b1; end
      OP_LW,
      OP_SW,
      OP_J,
      OP_JAL:  begin alu_op = ALUOp_ADDU; legal = 1'b1; end
      default: begin alu_op = ALUOp_ADDU; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// ---------------------------------------------------------------------------
// mc_ctrl_hs
// Multicycle MIPS control FSM with instruction/data memory ready handshakes
// and a retired-instruction counter. Outputs are decoded combinationally from
// the current state (plus zero / imem_rdy / dmem_rdy).
// Parameters: ALUOP_W (alu_op width), CNT_W (retired_cnt width).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   zero                   ALU zero flag for beq/bne
//   op, funct              IR fields
//   imem_rdy, dmem_rdy     memory completion handshakes
//   imem_req, dmem_req     memory requests
//   pc_wr, ir_wr, rf_wr, dm_wr   datapath write enables
//   ext_op, alu_op, npc_op, gpr_sel, wd_sel, b_sel   datapath selects
//   state_o                current state (debug)
//   retired_cnt            completed instructions, wrapping
//   trap                   illegal-instruction pulse (only with MC_CTRL_TRAP_EN)
// Build option: define MC_CTRL_TRAP_EN to add the TRAP state and trap port;
// otherwise unsupported instructions return DCD -> FETCH silently.
// ---------------------------------------------------------------------------
module mc_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               zero,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               imem_rdy,
  input  logic               dmem_rdy,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               rf_wr,
  output logic               dm_wr,
  output logic [1:0]         ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         npc_op,
  output logic [1:0]         gpr_sel,
  output logic [1:0]         wd_sel,
  output logic               b_sel,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   retired_cnt
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic               trap
`endif
);

  // Where DCD sends an unsupported instruction
`ifdef MC_CTRL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif

  state_e           state_r;
  state_e           next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             retire_s;
  logic [2:0]       dec_alu_s;
  logic             legal_s;
  logic             is_r_s;

  mc_alu_dec u_alu_dec (
    .op     (op),
    .funct  (funct),
    .alu_op (dec_alu_s),
    .legal  (legal_s)
  );

  assign is_r_s      = (op == OP_RTYPE);
  assign state_o     = state_r;
  assign retired_cnt = cnt_r;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_s;
      if (retire_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    next_s   = state_r;
    retire_s = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    rf_wr    = 1'b0;
    dm_wr    = 1'b0;
    ext_op   = EXT_ZERO;
    alu_op   = ALUOP_W'(ALUOp_ADDU);
    npc_op   = NPC_PC4;
    gpr_sel  = GPRSel_RD;
    wd_sel   = WDSel_ALU;
    b_sel    = 1'b0;
`ifdef MC_CTRL_TRAP_EN
    trap     = 1'b0;
`endif
    case (state_r)
      S_FETCH: begin
        // PC+4 and IR load happen on the same edge the fetch completes
        imem_req = 1'b1;
        pc_wr    = imem_rdy;
        ir_wr    = imem_rdy;
        if (imem_rdy) begin
          next_s = S_DCD;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DCD: begin
        if (!legal_s) begin
          next_s = ILLEGAL_NEXT;
        end else begin
          case (op)
            OP_RTYPE: begin
              if (funct == FN_JR) begin
                next_s = S_JMP;
              end else begin
                next_s = S_EXE;
              end
            end
            OP_ORI, OP_ADDI, OP_LUI: next_s = S_EXE;
            OP_LW, OP_SW:            next_s = S_MA;
            OP_BEQ, OP_BNE:          next_s = S_BRANCH;
            OP_J, OP_JAL:            next_s = S_JMP;
            default:                 next_s = ILLEGAL_NEXT;
          endcase
        end
      end
      S_EXE: begin
        alu_op = ALUOP_W'(dec_alu_s);
        b_sel  = is_imm_alu(op);
        case (op)
          OP_ADDI: ext_op = EXT_SIGNED;
          OP_LUI:  ext_op = EXT_UPPER;
          default: ext_op = EXT_ZERO;
        endcase
        next_s = S_WB;
      end
      S_WB: begin
        rf_wr    = 1'b1;
        wd_sel   = WDSel_ALU;
        if (is_imm_alu(op)) begin
          gpr_sel = GPRSel_RT;
        end else begin
          gpr_sel = GPRSel_RD;
        end
        retire_s = 1'b1;
        next_s   = S_FETCH;
      end
      S_MA: begin
        ext_op = EXT_SIGNED;
        b_sel  = 1'b1;
        alu_op = ALUOP_W'(ALUOp_ADDU);
        if (op == OP_LW) begin
          next_s = S_MR;
        end else begin
          next_s = S_MW;
        end
      end
      S_MR: begin
        dmem_req = 1'b1;
        if (dmem_rdy) begin
          next_s = S_MEMWB;
        end else begin
          next_s = S_MR;
        end
      end
      S_MEMWB: begin
        rf_wr    = 1'b1;
        gpr_sel  = GPRSel_RT;
        wd_sel   = WDSel_MEM;
        retire_s = 1'b1;
        next_s   = S_FETCH;
      end
      S_MW: begin
        // Write strobe stays up for the whole access, including wait cycles
        dmem_req = 1'b1;
        dm_wr    = 1'b1;
        if (dmem_rdy) begin
          retire_s = 1'b1;
          next_s   = S_FETCH;
        end else begin
          next_s   = S_MW;
        end
      end
      S_BRANCH: begin
        npc_op = NPC_BRANCH;
        ext_op = EXT_SIGNED;
        alu_op = ALUOP_W'(ALUOp_SUBU);
        if (op == OP_BNE) begin
          pc_wr = ~zero;
        end else begin
          pc_wr = zero;
        end
        retire_s = 1'b1;
        next_s   = S_FETCH;
      end
      S_JMP: begin
        pc_wr = 1'b1;
        if (is_r_s) begin
          npc_op = NPC_REG;
        end else if (op == OP_JAL) begin
          npc_op  = NPC_JUMP;
          rf_wr   = 1'b1;
          gpr_sel = GPRSel_RA;
          wd_sel  = WDSel_PC;
        end else begin
          npc_op = NPC_JUMP;
        end
        retire_s = 1'b1;
        next_s   = S_FETCH;
      end
`ifdef MC_CTRL_TRAP_EN
      S_TRAP: begin
        trap   = 1'b1;
        next_s = S_FETCH;
      end
`endif
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_hs
// Self-checking bench for mc_ctrl_hs. Each scenario pushes per-cycle input
// values and the expected output vector into a queue, then replays it,
// comparing the DUT outputs on the falling edge. CNT_W is shrunk to 4 so the
// retired counter wraps within the run.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_hs;
  import mc_ctrl_pkg::*;

  localparam int ALUOP_W = 5;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               zero = 1'b0;
  logic [5:0]         op = 6'h00;
  logic [5:0]         funct = 6'h00;
  logic               imem_rdy = 1'b0;
  logic               dmem_rdy = 1'b0;
  logic               imem_req, dmem_req, pc_wr, ir_wr, rf_wr, dm_wr, b_sel;
  logic [1:0]         ext_op, npc_op, gpr_sel, wd_sel;
  logic [ALUOP_W-1:0] alu_op;
  logic [3:0]         state_o;
  logic [CNT_W-1:0]   retired_cnt;
  logic               trap_v;

  mc_ctrl_hs #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .zero(zero), .op(op), .funct(funct),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .dm_wr(dm_wr),
    .ext_op(ext_op), .alu_op(alu_op), .npc_op(npc_op),
    .gpr_sel(gpr_sel), .wd_sel(wd_sel), .b_sel(b_sel),
    .state_o(state_o), .retired_cnt(retired_cnt)
`ifdef MC_CTRL_TRAP_EN
    , .trap(trap_v)
`endif
  );

`ifndef MC_CTRL_TRAP_EN
  assign trap_v = 1'b0;
`endif

  always #5 clk = ~clk;

  // Observed vector: trap, state, {imem_req,dmem_req,pc_wr,ir_wr,rf_wr,dm_wr},
  // ext_op, alu_op, npc_op, gpr_sel, wd_sel, b_sel, retired_cnt
  logic [28:0] obs;
  assign obs = {trap_v, state_o, imem_req, dmem_req, pc_wr, ir_wr, rf_wr, dm_wr,
                ext_op, alu_op, npc_op, gpr_sel, wd_sel, b_sel, retired_cnt};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        ir;
    logic        dr;
    logic        z;
    logic [28:0] exp;
  } ent_t;

  ent_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic [5:0] nop = 6'h00;
  logic [5:0] nfn = 6'h00;

  // Expected control word (without the counter field)
  function automatic logic [24:0] c(input logic [3:0] st, input logic [5:0] en,
                                    input logic [1:0] ext, input logic [2:0] alu,
                                    input logic [1:0] npc, input logic [1:0] gs,
                                    input logic [1:0] ws, input logic bs);
    return {1'b0, st, en, ext, {2'b00, alu}, npc, gs, ws, bs};
  endfunction

  function automatic void push(input logic ir, input logic dr, input logic z,
                               input logic [24:0] ctl);
    ent_t e;
    e.op = nop; e.fn = nfn; e.ir = ir; e.dr = dr; e.z = z;
    e.exp = {ctl, exp_cnt};
    sb.push_back(e);
  endfunction

  function automatic void push_fetch(input logic rdy);
    push(rdy, 1'b0, 1'b0, c(S_FETCH, rdy ? 6'b101100 : 6'b100000, EXT_ZERO,
                            ALUOp_ADDU, NPC_PC4, GPRSel_RD, WDSel_ALU, 1'b0));
  endfunction

  function automatic void push_dcd();
    push(1'b0, 1'b1, 1'b0, c(S_DCD, 6'b000000, EXT_ZERO, ALUOp_ADDU,
                             NPC_PC4, GPRSel_RD, WDSel_ALU, 1'b0));
  endfunction

  task automatic test_reset();
    rst = 1'b1; imem_rdy = 1'b1; dmem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== {c(S_FETCH, 6'b100000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                   GPRSel_RD, WDSel_ALU, 1'b0), 4'd0}) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", obs,
               {c(S_FETCH, 6'b100000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                  GPRSel_RD, WDSel_ALU, 1'b0), 4'd0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addu();
    ent_t cur;
    nop = OP_RTYPE; nfn = FN_ADDU;
    push_fetch(1'b0);
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b0, 1'b0, c(S_EXE, 6'b000000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    push(1'b0, 1'b0, 1'b0, c(S_WB, 6'b000010, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    exp_cnt++;
    push_fetch(1'b0);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL addu: got %h expected %h", obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    ent_t cur;
    logic [5:0] t_op [7] = '{OP_ORI, OP_ADDI, OP_LUI, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE};
    logic [5:0] t_fn [7] = '{6'h00, 6'h00, 6'h00, FN_SUBU, FN_AND, FN_OR, FN_SLT};
    logic [2:0] t_alu[7] = '{ALUOp_OR, ALUOp_ADDU, ALUOp_LUI, ALUOp_SUBU, ALUOp_AND, ALUOp_OR, ALUOp_SLT};
    logic [1:0] t_ext[7] = '{EXT_ZERO, EXT_SIGNED, EXT_UPPER, EXT_ZERO, EXT_ZERO, EXT_ZERO, EXT_ZERO};
    logic       t_imm[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      nop = t_op[i]; nfn = t_fn[i];
      push_fetch(1'b1);
      push_dcd();
      push(1'b0, 1'b0, 1'b0, c(S_EXE, 6'b000000, t_ext[i], t_alu[i], NPC_PC4,
                               GPRSel_RD, WDSel_ALU, t_imm[i]));
      push(1'b0, 1'b0, 1'b0, c(S_WB, 6'b000010, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                               t_imm[i] ? GPRSel_RT : GPRSel_RD, WDSel_ALU, 1'b0));
      exp_cnt++;
    end
    push_fetch(1'b0);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL alu_ops op=%h fn=%h: got %h expected %h", cur.op, cur.fn, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    ent_t cur;
    nop = OP_LW; nfn = 6'h00;
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b1, 1'b0, c(S_MA, 6'b000000, EXT_SIGNED, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b1));
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 1'b0, c(S_MR, 6'b010000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                               GPRSel_RD, WDSel_ALU, 1'b0));
    end
    push(1'b0, 1'b1, 1'b0, c(S_MR, 6'b010000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    push(1'b0, 1'b0, 1'b0, c(S_MEMWB, 6'b000010, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RT, WDSel_MEM, 1'b0));
    exp_cnt++;
    nop = OP_SW;
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b1, 1'b0, c(S_MA, 6'b000000, EXT_SIGNED, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b1));
    push(1'b0, 1'b0, 1'b0, c(S_MW, 6'b010001, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    push(1'b0, 1'b1, 1'b0, c(S_MW, 6'b010001, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    exp_cnt++;
    push_fetch(1'b0);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL mem_wait op=%h: got %h expected %h", cur.op, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    ent_t cur;
    logic [5:0] b_op[4] = '{OP_BEQ, OP_BNE, OP_BEQ, OP_BNE};
    logic       b_z [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       b_pw[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      nop = b_op[i]; nfn = 6'h00;
      push_fetch(1'b1);
      push_dcd();
      push(1'b0, 1'b0, b_z[i], c(S_BRANCH, {2'b00, b_pw[i], 3'b000}, EXT_SIGNED,
                                 ALUOp_SUBU, NPC_BRANCH, GPRSel_RD, WDSel_ALU, 1'b0));
      exp_cnt++;
    end
    push_fetch(1'b0);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL branch op=%h zero=%b: got %h expected %h", cur.op, cur.z, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    ent_t cur;
    nop = OP_JAL; nfn = 6'h00;
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b0, 1'b0, c(S_JMP, 6'b001010, EXT_ZERO, ALUOp_ADDU, NPC_JUMP,
                             GPRSel_RA, WDSel_PC, 1'b0));
    exp_cnt++;
    nop = OP_J;
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b0, 1'b0, c(S_JMP, 6'b001000, EXT_ZERO, ALUOp_ADDU, NPC_JUMP,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    exp_cnt++;
    nop = OP_RTYPE; nfn = FN_JR;
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b0, 1'b0, c(S_JMP, 6'b001000, EXT_ZERO, ALUOp_ADDU, NPC_REG,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    exp_cnt++;
    push_fetch(1'b0);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL jump op=%h fn=%h: got %h expected %h", cur.op, cur.fn, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    ent_t cur;
    nop = OP_SW; nfn = 6'h00;
    push_fetch(1'b1);
    push_dcd();
    push(1'b0, 1'b0, 1'b0, c(S_MA, 6'b000000, EXT_SIGNED, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b1));
    push(1'b0, 1'b0, 1'b0, c(S_MW, 6'b010001, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                             GPRSel_RD, WDSel_ALU, 1'b0));
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL rst_mid setup: got %h expected %h", obs, cur.exp);
      end
      @(posedge clk); #1;
    end
    // Still waiting in MW; reset must win over the pending write
    rst = 1'b1; dmem_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; imem_rdy = 1'b0;
    exp_cnt = 4'd0;
    @(negedge clk);
    vectors++;
    if (obs !== {c(S_FETCH, 6'b100000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                   GPRSel_RD, WDSel_ALU, 1'b0), exp_cnt}) begin
      miscompares++;
      $display("FAIL rst_mid: got %h expected %h", obs,
               {c(S_FETCH, 6'b100000, EXT_ZERO, ALUOp_ADDU, NPC_PC4,
                  GPRSel_RD, WDSel_ALU, 1'b0), exp_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    ent_t cur;
    logic [5:0] i_op[2] = '{6'h3F, OP_RTYPE};
    logic [5:0] i_fn[2] = '{6'h00, 6'h00};
    for (int i = 0; i < 2; i++) begin
      nop = i_op[i]; nfn = i_fn[i];
      push_fetch(1'b1);
      push_dcd();
`ifdef MC_CTRL_TRAP_EN
      push(1'b0, 1'b0, 1'b0, {1'b1, 4'hA, 20'd0});
`endif
    end
    push_fetch(1'b0);
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      op = cur.op; funct = cur.fn; imem_rdy = cur.ir; dmem_rdy = cur.dr; zero = cur.z;
      @(negedge clk);
      vectors++;
      if (obs !== cur.exp) begin
        miscompares++;
        $display("FAIL illegal op=%h fn=%h: got %h expected %h", cur.op, cur.fn, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_alu_ops();
    test_mem_wait();
    test_branch();
    test_jump();
    test_reset_mid_wait();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
